// File: rtl/pipe_pkg.sv
// Shared constants and stage record for the pipe_stage_chain codebase slice.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned REG_ZERO         = 0;

  // Reference layout of one stage at default widths (DATA_W=32, ADDR_W=5, CTRL_W=2).
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [1:0]  ctrl;
    logic [31:0] data;
  } stage_rec_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline register stage: async active-low reset, flush-to-bubble, stall-hold.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CTRL_W   = 2,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RESET;
      out_instr <= NOP_INSTR;
      out_wen   <= 1'b0;
      out_waddr <= '0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RESET;
      out_instr <= NOP_INSTR;
      out_wen   <= 1'b0;
      out_waddr <= '0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_wen   <= in_wen;
      out_waddr <= in_waddr;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline latch chain with valid/stall/flush and forwarding lookup.
// Optional counters stall_cnt/bubble_cnt enabled by PIPE_STAGE_CHAIN_STAT_EN.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CTRL_W   = 2,
  parameter int unsigned DEPTH    = 1,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`ifdef PIPE_STAGE_CHAIN_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]             st_valid;
  logic [DEPTH-1:0][31:0]       st_pc;
  logic [DEPTH-1:0][31:0]       st_instr;
  logic [DEPTH-1:0]             st_wen;
  logic [DEPTH-1:0][ADDR_W-1:0] st_waddr;
  logic [DEPTH-1:0][CTRL_W-1:0] st_ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] st_data;
  logic [DEPTH-1:0]             st_match;

  logic              s0_wen;
  logic [CTRL_W-1:0] s0_ctrl;

  // Bubbles never carry write intent; later stages inherit the sanitised fields.
  assign s0_wen  = in_valid & in_wen;
  assign s0_ctrl = in_valid ? in_ctrl : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      pipe_stage_slot #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CTRL_W   (CTRL_W),
        .PC_RESET (PC_RESET)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_wen    (s0_wen),
        .in_waddr  (in_waddr),
        .in_ctrl   (s0_ctrl),
        .in_data   (in_data),
        .out_valid (st_valid[g]),
        .out_pc    (st_pc[g]),
        .out_instr (st_instr[g]),
        .out_wen   (st_wen[g]),
        .out_waddr (st_waddr[g]),
        .out_ctrl  (st_ctrl[g]),
        .out_data  (st_data[g])
      );
    end else begin : g_body
      pipe_stage_slot #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CTRL_W   (CTRL_W),
        .PC_RESET (PC_RESET)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (st_valid[g-1]),
        .in_pc     (st_pc[g-1]),
        .in_instr  (st_instr[g-1]),
        .in_wen    (st_wen[g-1]),
        .in_waddr  (st_waddr[g-1]),
        .in_ctrl   (st_ctrl[g-1]),
        .in_data   (st_data[g-1]),
        .out_valid (st_valid[g]),
        .out_pc    (st_pc[g]),
        .out_instr (st_instr[g]),
        .out_wen   (st_wen[g]),
        .out_waddr (st_waddr[g]),
        .out_ctrl  (st_ctrl[g]),
        .out_data  (st_data[g])
      );
    end

    assign st_match[g] = st_valid[g] & st_wen[g] & (st_waddr[g] == q_addr)
                       & (q_addr != ADDR_W'(REG_ZERO));
  end

  // Youngest stage (index 0) wins: the first match found stops further updates.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (st_match[i] && !fwd_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = st_data[i];
      end
    end
  end

  assign out_valid = st_valid[DEPTH-1];
  assign out_pc    = st_pc[DEPTH-1];
  assign out_instr = st_instr[DEPTH-1];
  assign out_wen   = st_valid[DEPTH-1] & st_wen[DEPTH-1];
  assign out_waddr = st_waddr[DEPTH-1];
  assign out_ctrl  = st_ctrl[DEPTH-1];
  assign out_data  = st_data[DEPTH-1];

`ifdef PIPE_STAGE_CHAIN_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid)      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain at DEPTH=2.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        in_valid, in_wen;
  logic [31:0] in_pc, in_instr, in_data;
  logic [4:0]  in_waddr, q_addr;
  logic [1:0]  in_ctrl;
  logic        out_valid, out_wen, fwd_hit;
  logic [31:0] out_pc, out_instr, out_data, fwd_data;
  logic [4:0]  out_waddr;
  logic [1:0]  out_ctrl;
`ifdef PIPE_STAGE_CHAIN_STAT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_wen    (in_wen),
    .in_waddr  (in_waddr),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .q_addr    (q_addr),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_wen   (out_wen),
    .out_waddr (out_waddr),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`ifdef PIPE_STAGE_CHAIN_STAT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic we, input logic [4:0] wa, input logic [31:0] d);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
    in_wen   = we;
    in_waddr = wa;
    in_ctrl  = 2'd1;
    in_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h5555_5555);
    q_addr = 5'd3;
    tick();
    tick();
    n_cmp++; if (out_pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc got %h want %h", out_pc, 32'h0000_3000); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", out_wen); end
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL reset_fwd_hit got %b want 0", fwd_hit); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
    reset = 1'b1;
    drive(1'b1, 32'h0000_3004, 32'h0000_0011, 1'b0, 5'd0, 32'h0);
    tick();
    n_cmp++; if (out_pc !== 32'h0000_3000) begin n_err++; $display("FAIL latency1_pc got %h want %h", out_pc, 32'h0000_3000); end
    tick();
    n_cmp++; if (out_pc !== 32'h0000_3004) begin n_err++; $display("FAIL latency2_pc got %h want %h", out_pc, 32'h0000_3004); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency2_valid got %b want 1", out_valid); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h100, 32'hA1, 1'b1, 5'd1, 32'h0A); tick();
    drive(1'b1, 32'h104, 32'hB1, 1'b1, 5'd2, 32'h0B); tick();
    drive(1'b1, 32'h108, 32'hC1, 1'b1, 5'd3, 32'h0C); tick();
    n_cmp++; if (out_pc !== 32'h104) begin n_err++; $display("FAIL stall_pre_pc got %h want 104", out_pc); end
    stall  = 1'b1;
    q_addr = 5'd3;
    drive(1'b1, 32'h200, 32'hEE, 1'b1, 5'd3, 32'hEE);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_pc !== 32'h104) begin n_err++; $display("FAIL stall_hold_pc[%0d] got %h want 104", i, out_pc); end
      n_cmp++; if (out_instr !== 32'hB1) begin n_err++; $display("FAIL stall_hold_instr[%0d] got %h want b1", i, out_instr); end
      n_cmp++; if (fwd_data !== 32'h0C) begin n_err++; $display("FAIL stall_hold_stage0[%0d] got %h want c", i, fwd_data); end
      drive(1'b1, 32'h200 + 32'(i), 32'hEE, 1'b1, 5'd3, 32'hEE);
    end
    stall = 1'b0;
    drive(1'b1, 32'h10C, 32'hD1, 1'b1, 5'd4, 32'h0D); tick();
    n_cmp++; if (out_pc !== 32'h108) begin n_err++; $display("FAIL stall_resume_c got %h want 108", out_pc); end
    drive(1'b1, 32'h110, 32'hE1, 1'b1, 5'd5, 32'h0E); tick();
    n_cmp++; if (out_pc !== 32'h10C) begin n_err++; $display("FAIL stall_resume_d got %h want 10c", out_pc); end
    n_cmp++; if (out_data !== 32'h0D) begin n_err++; $display("FAIL stall_resume_d_data got %h want d", out_data); end
  endtask

  task automatic test_flush_stall();
    q_addr = 5'd4;
    flush  = 1'b1;
    stall  = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL flush_instr got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 32'h0000_3000) begin n_err++; $display("FAIL flush_pc got %h want 3000", out_pc); end
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL flush_fwd_hit got %b want 0", fwd_hit); end
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b1, 32'h300, 32'hF1, 1'b1, 5'd9, 32'hF00D);
    q_addr = 5'd9;
    tick();
    n_cmp++; if (fwd_hit !== 1'b1) begin n_err++; $display("FAIL flush_reload_hit got %b want 1", fwd_hit); end
    n_cmp++; if (fwd_data !== 32'hF00D) begin n_err++; $display("FAIL flush_reload_data got %h want f00d", fwd_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_reload_out_valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_pc !== 32'h300) begin n_err++; $display("FAIL flush_reload_pc got %h want 300", out_pc); end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 32'h400, 32'h1, 1'b1, 5'd8, 32'hBBBB); tick();
    drive(1'b1, 32'h404, 32'h2, 1'b1, 5'd8, 32'hAAAA); tick();
    q_addr = 5'd8; #1;
    n_cmp++; if (fwd_hit !== 1'b1) begin n_err++; $display("FAIL fwd_prio_hit got %b want 1", fwd_hit); end
    n_cmp++; if (fwd_data !== 32'hAAAA) begin n_err++; $display("FAIL fwd_prio_data got %h want aaaa", fwd_data); end
    drive(1'b1, 32'h408, 32'h3, 1'b1, 5'd0, 32'hCCCC); tick();
    q_addr = 5'd0; #1;
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_zero_hit got %b want 0", fwd_hit); end
    n_cmp++; if (fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_zero_data got %h want 0", fwd_data); end
    q_addr = 5'd8; #1;
    n_cmp++; if (fwd_data !== 32'hAAAA) begin n_err++; $display("FAIL fwd_older_data got %h want aaaa", fwd_data); end
    q_addr = 5'd7; #1;
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_miss_hit got %b want 0", fwd_hit); end
  endtask

  task automatic test_bubble();
    drive(1'b0, 32'h500, 32'h77, 1'b1, 5'd5, 32'h55);
    in_ctrl = 2'd3;
    q_addr  = 5'd5;
    tick();
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL bubble_fwd_hit got %b want 0", fwd_hit); end
    tick();
    n_cmp++; if (out_wen !== 1'b0) begin n_err++; $display("FAIL bubble_wen got %b want 0", out_wen); end
    n_cmp++; if (out_ctrl !== 2'd0) begin n_err++; $display("FAIL bubble_ctrl got %h want 0", out_ctrl); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h55) begin n_err++; $display("FAIL bubble_data got %h want 55", out_data); end
    n_cmp++; if (out_pc !== 32'h500) begin n_err++; $display("FAIL bubble_pc got %h want 500", out_pc); end
  endtask

`ifdef PIPE_STAGE_CHAIN_STAT_EN
  task automatic test_stats();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    reset = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    n_cmp++; if (stall_cnt !== 32'd4) begin n_err++; $display("FAIL stat_stall_cnt got %0d want 4", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 32'd5) begin n_err++; $display("FAIL stat_bubble_cnt got %0d want 5", bubble_cnt); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stat_async_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 32'd0) begin n_err++; $display("FAIL stat_async_bubble got %0d want 0", bubble_cnt); end
    tick();
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_flush_stall();
    test_forwarding();
    test_bubble();
`ifdef PIPE_STAGE_CHAIN_STAT_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
